// File: rtl/led_fade_pkg.sv
// Shared types and defaults for the RGB LED fade sequencer.
// The gamma helper is used by pwm_channel when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

  localparam int unsigned PWM_W_DEF  = 12;
  localparam int unsigned RATE_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Perceptual curve: (x * x) >> w, valid for levels up to 32 bits wide.
  function automatic logic [31:0] gamma(input logic [31:0] lvl, input int unsigned w);
    logic [63:0] sq;
    sq = 64'(lvl) * 64'(lvl);
    sq = sq >> w;
    return sq[31:0];
  endfunction

endpackage

// File: rtl/led_fade_ctrl_pwm_channel.sv
// One PWM compare channel: duty shadow register reloaded on tick, active-low pin.
// Build option LED_FADE_GAMMA_EN inserts the gamma stage in front of the duty register.
module pwm_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [PWM_W-1:0] cnt_nxt,
  input  logic [PWM_W-1:0] level_src,
  output logic             led
);

  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_src;
  logic [PWM_W-1:0] duty_nxt;

`ifdef LED_FADE_GAMMA_EN
  assign duty_src = PWM_W'(gamma(32'(level_src), PWM_W));
`else
  assign duty_src = level_src;
`endif

  assign duty_nxt = tick ? duty_src : duty;

  // Pin is computed from next-cycle counter/duty so the flop tracks the compare exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      led  <= 1'b1;
    end else begin
      duty <= duty_nxt;
      led  <= (cnt_nxt >= duty_nxt);
    end
  end

endmodule

// File: rtl/led_fade_ctrl.sv
// RGB LED brightness sequencer: accepts fade commands and ramps three PWM levels.
// Optional gamma-corrected duty via LED_FADE_GAMMA_EN (see pwm_channel).
module led_fade_ctrl
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_W  = PWM_W_DEF,
  parameter int unsigned RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PWM_W-1:0]  cmd_r,
  input  logic [PWM_W-1:0]  cmd_g,
  input  logic [PWM_W-1:0]  cmd_b,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic              led_r,
  output logic              led_g,
  output logic              led_b,
  output logic              busy,
  output logic              done
);

  localparam int unsigned N_CH = 3;

  state_t            state, state_d;
  logic [PWM_W-1:0]  pwm_cnt, cnt_nxt;
  logic [RATE_W-1:0] div_cnt, div_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [PWM_W-1:0]  level_q  [N_CH];
  logic [PWM_W-1:0]  level_d  [N_CH];
  logic [PWM_W-1:0]  target_q [N_CH];
  logic [PWM_W-1:0]  target_d [N_CH];
  logic [PWM_W-1:0]  step_lvl [N_CH];
  logic [PWM_W-1:0]  duty_src [N_CH];
  logic [PWM_W-1:0]  cmd_lvl  [N_CH];
  logic [N_CH-1:0]   led_vec;
  logic              tick, accept, step_now, all_eq, done_d;

  assign cmd_lvl[0] = cmd_r;
  assign cmd_lvl[1] = cmd_g;
  assign cmd_lvl[2] = cmd_b;

  assign tick    = &pwm_cnt;
  assign cnt_nxt = pwm_cnt + 1'b1;
  assign accept  = cmd_valid && cmd_ready;

  // Step toward target without wrapping; equal channels hold.
  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      step_lvl[i] = level_q[i];
      if (level_q[i] < target_q[i]) begin
        step_lvl[i] = level_q[i] + 1'b1;
      end else if (level_q[i] > target_q[i]) begin
        step_lvl[i] = level_q[i] - 1'b1;
      end
      if (step_lvl[i] != target_q[i]) begin
        all_eq = 1'b0;
      end
    end
  end

  assign step_now = (state == RAMP) && tick && (div_cnt <= RATE_W'(1));

  // Duty reload sees the stepped level on a step tick, otherwise the committed level.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_src[i] = step_now ? step_lvl[i] : level_q[i];
    end
  end

  always_comb begin
    state_d  = state;
    div_d    = div_cnt;
    rate_d   = rate_q;
    level_d  = level_q;
    target_d = target_q;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          target_d = cmd_lvl;
          rate_d   = cmd_rate;
          if (cmd_rate == '0) begin
            level_d = cmd_lvl;
            done_d  = 1'b1;
          end else begin
            div_d   = cmd_rate;
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (tick) begin
          if (div_cnt > RATE_W'(1)) begin
            div_d = div_cnt - 1'b1;
          end else begin
            level_d = step_lvl;
            div_d   = rate_q;
            if (all_eq) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pwm_cnt   <= '0;
      div_cnt   <= '0;
      rate_q    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        level_q[i]  <= '0;
        target_q[i] <= '0;
      end
    end else begin
      state     <= state_d;
      pwm_cnt   <= cnt_nxt;
      div_cnt   <= div_d;
      rate_q    <= rate_d;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d == RAMP);
      done      <= done_d;
      level_q   <= level_d;
      target_q  <= target_d;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .cnt_nxt   (cnt_nxt),
      .level_src (duty_src[c]),
      .led       (led_vec[c])
    );
  end

  assign led_r = led_vec[0];
  assign led_g = led_vec[1];
  assign led_b = led_vec[2];

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Bench for led_fade_ctrl: per-period LED low-time scoreboard plus handshake/done checks.
module tb_led_fade_ctrl;

  localparam int unsigned PW = 12;
  localparam int unsigned RW = 8;
  localparam int          MAXC = 70000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [PW-1:0] cmd_r = '0, cmd_g = '0, cmd_b = '0;
  logic [RW-1:0] cmd_rate = '0;
  logic          led_r, led_g, led_b, busy, done;

  led_fade_ctrl #(.PWM_W(PW), .RATE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b), .cmd_rate(cmd_rate),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int pn; int r; int g; int b;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference phase and period index, independent of the DUT.
  logic [PW-1:0] ph;
  int            pidx;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= '0;
      pidx <= 0;
    end else begin
      ph <= ph + 1'b1;
      if (ph == '1) pidx <= pidx + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dty(input int x);
`ifdef LED_FADE_GAMMA_EN
    return (x * x) >> PW;
`else
    return x;
`endif
  endfunction

  task automatic push_exp(input int pn, input int r, input int g, input int b);
    exp_t e;
    e.pn = pn; e.r = dty(r); e.g = dty(g); e.b = dty(b);
    q.push_back(e);
  endtask

  // Count low clocks per period and compare against queued expectations.
  initial begin
    int lr, lg, lb;
    exp_t e;
    lr = 0; lg = 0; lb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lr = 0; lg = 0; lb = 0;
      end else begin
        lr += int'(!led_r);
        lg += int'(!led_g);
        lb += int'(!led_b);
        if (ph == '1) begin
          while (q.size() > 0 && q[0].pn < pidx) begin
            e = q.pop_front();
            chk("missed_period", e.pn, pidx);
          end
          while (q.size() > 0 && q[0].pn == pidx) begin
            e = q.pop_front();
            chk("low_r", lr, e.r);
            chk("low_g", lg, e.g);
            chk("low_b", lb, e.b);
          end
          lr = 0; lg = 0; lb = 0;
        end
      end
    end
  end

  task automatic skip_to(input int pn, input int p);
    int n;
    n = 0;
    while (!(pidx == pn && int'(ph) == p) && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    if (n >= MAXC) chk("skip_timeout", n, 0);
  endtask

  // Starts and ends on a negedge; returns on the negedge after the accept edge.
  task automatic send(input int r, input int g, input int b, input int rate);
    int n;
    cmd_r = PW'(r); cmd_g = PW'(g); cmd_b = PW'(b); cmd_rate = RW'(rate);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    if (n >= MAXC) chk("accept_timeout", n, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_pn, input string tag);
    int n;
    n = 0;
    while (!done && n < MAXC) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, int'(done), 1);
    chk({tag, "_period"}, pidx, exp_pn);
    chk({tag, "_phase"}, int'(ph), 0);
    chk({tag, "_ready"}, int'(cmd_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int qp;
    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_led_r", int'(led_r), 1);
    chk("rst_led_g", int'(led_g), 1);
    chk("rst_led_b", int'(led_b), 1);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    push_exp(0, 0, 0, 0);

    // Immediate jump to 4095/0/2048.
    skip_to(0, 100);
    push_exp(1, 4095, 0, 2048);
    send(4095, 0, 2048, 0);
    chk("jump_done", int'(done), 1);
    chk("jump_ready", int'(cmd_ready), 1);
    chk("jump_busy", int'(busy), 0);
    @(negedge clk);
    chk("jump_done_clr", int'(done), 0);

    // Accept on a tick cycle: that reload keeps the old levels.
    skip_to(1, 4095);
    push_exp(2, 4095, 0, 2048);
    push_exp(3, 0, 0, 0);
    send(0, 0, 0, 0);
    chk("tick_done", int'(done), 1);

    // Ramp red 0 -> 3 at rate 2.
    skip_to(3, 200);
    push_exp(3, 0, 0, 0); push_exp(4, 0, 0, 0);
    push_exp(5, 1, 0, 0); push_exp(6, 1, 0, 0);
    push_exp(7, 2, 0, 0); push_exp(8, 2, 0, 0);
    push_exp(9, 3, 0, 0);
    send(3, 0, 0, 2);
    chk("ramp_busy", int'(busy), 1);
    chk("ramp_ready", int'(cmd_ready), 0);
    chk("ramp_done0", int'(done), 0);
    wait_done(9, "ramp_done");
    @(negedge clk);
    chk("ramp_done_clr", int'(done), 0);

    // Command B held valid while command A ramps.
    skip_to(9, 300);
    push_exp(9, 3, 0, 0);
    push_exp(10, 3, 1, 1);
    send(3, 2, 1, 1);
    cmd_r = PW'(0); cmd_g = PW'(4); cmd_b = PW'(1); cmd_rate = RW'(1);
    cmd_valid = 1'b1;
    wait_done(11, "a_done");
    qp = pidx;
    push_exp(qp, 3, 2, 1);
    push_exp(qp + 1, 2, 3, 1);
    push_exp(qp + 2, 1, 4, 1);
    push_exp(qp + 3, 0, 4, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b_busy", int'(busy), 1);
    chk("b_ready", int'(cmd_ready), 0);
    wait_done(qp + 3, "b_done");

    // Reset in the middle of a long ramp.
    skip_to(14, 300);
    send(100, 0, 0, 3);
    skip_to(15, 100);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led_r", int'(led_r), 1);
    chk("mid_rst_led_g", int'(led_g), 1);
    chk("mid_rst_led_b", int'(led_b), 1);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 0, 0, 0);
    push_exp(1, 1, 0, 0);
    skip_to(0, 300);
    send(1, 0, 0, 1);
    wait_done(1, "post_rst_done");

    skip_to(2, 5);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
